// File: rtl/ram_reader_pkg.sv
// -----------------------------------------------------------------------------
// ram_reader_pkg
// Shared definitions for the RAM stream reader slice: the reader FSM state
// encoding and the default geometry of the RAM it reads from.
// No ports (package).
// -----------------------------------------------------------------------------
package ram_reader_pkg;

  localparam int RR_ADDR_WIDTH = 7;
  localparam int RR_DATA_WIDTH = 20;
  localparam int RR_MEM_SIZE   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
// Two-port RAM with a 2-stage read pipeline on each port: the address
// register and the output data register advance only on edges with en=1,
// so a port with en=0 freezes both its address and its read data.
// Writes happen on edges with en=1 and we=1, at the presented address.
// Ports (per side x in {a,b}):
//   clk            clock, all logic on posedge
//   en_x           pipeline advance / write enable qualifier
//   we_x           write enable
//   addr_x, din_x  address and write data
//   dout_x         registered read data (two en-edges after the address)
// -----------------------------------------------------------------------------
module dual_port_ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 20,
  parameter int MEM_SIZE   = 128
) (
  input  logic                  clk,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [ADDR_WIDTH-1:0] addr_a_reg;
  logic [ADDR_WIDTH-1:0] addr_b_reg;
  logic [DATA_WIDTH-1:0] dout_a_reg;
  logic [DATA_WIDTH-1:0] dout_b_reg;

  // Both write ports live in one process so the array has a single driver.
  always_ff @(posedge clk) begin
    if (en_a && we_a) mem[addr_a] <= din_a;
    if (en_b && we_b) mem[addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (en_a) begin
      addr_a_reg <= addr_a;
      dout_a_reg <= mem[addr_a_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (en_b) begin
      addr_b_reg <= addr_b;
      dout_b_reg <= mem[addr_b_reg];
    end
  end

  assign dout_a = dout_a_reg;
  assign dout_b = dout_b_reg;

endmodule

// File: rtl/ram_stream_reader.sv
// -----------------------------------------------------------------------------
// ram_stream_reader
// Reads a burst of `length` consecutive words (wrapping at MEM_SIZE) from one
// port of a RAM with a 2-stage registered read pipeline and presents them as
// a valid/ready stream with a last-beat marker.
// Ports:
//   clk, rst_n                  clock (posedge) and async active-low reset
//   start, base_addr, length    burst request, sampled only in IDLE
//   busy, done                  burst in progress / one-cycle completion pulse
//   ram_en, ram_we, ram_addr,
//   ram_din, ram_dout           RAM port (read only, ram_en = pipeline advance)
//   m_valid, m_data, m_last,
//   m_ready                     stream output with backpressure
// -----------------------------------------------------------------------------
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = RR_ADDR_WIDTH,
  parameter int MEM_SIZE   = RR_MEM_SIZE,
  parameter int DATA_WIDTH = RR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
  logic                  done_reg, done_next;
  // v1/v2 track which RAM pipeline stages hold a requested word;
  // last1/last2 ride alongside to mark the final word of the burst.
  logic                  v1_reg, v2_reg;
  logic                  last1_reg, last2_reg;

  logic adv;
  logic issuing;
  logic final_issue;

  // The whole pipeline (RAM registers included) stalls only when the output
  // stage holds a beat the consumer is not taking.
  assign adv         = !v2_reg || m_ready;
  assign issuing     = (state_reg == RUN);
  assign final_issue = issuing && (remaining_reg == LEN_ONE);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next     = RUN;
            addr_next      = base_addr;
            remaining_next = length;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (adv) begin
          remaining_next = remaining_reg - LEN_ONE;
          if (remaining_reg == LEN_ONE) begin
            // Keep the final address so ram_addr stays put while draining.
            state_next = DRAIN;
          end else begin
            // Explicit compare so non-power-of-two MEM_SIZE wraps correctly.
            addr_next = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_ONE;
          end
        end
      end
      DRAIN: begin
        if (v2_reg && last2_reg && m_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      last1_reg <= 1'b0;
      last2_reg <= 1'b0;
    end else if (adv) begin
      v1_reg    <= issuing;
      v2_reg    <= v1_reg;
      last1_reg <= final_issue;
      last2_reg <= last1_reg;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign ram_en   = adv;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign ram_addr = addr_reg;
  assign m_valid  = v2_reg;
  assign m_data   = ram_dout;
  assign m_last   = v2_reg && last2_reg;

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, RAM address width.
REQ-002 The block SHALL have parameter MEM_SIZE, default 128, number of RAM words; wrap point for addresses.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 20, RAM word width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 The block SHALL have port base_addr, input, ADDR_WIDTH, first word address; sampled with start.
REQ-008 The block SHALL have port length, input, ADDR_WIDTH+1, word count 0..MEM_SIZE; sampled with start.
REQ-009 The block SHALL have port busy, output, 1, high from start acceptance until done.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse at burst completion.
REQ-011 The block SHALL have ports ram_en, ram_we, ram_addr, ram_din, outputs of width 1, 1, ADDR_WIDTH and DATA_WIDTH, driving one RAM port; ram_we and ram_din are tied to 0.
REQ-012 The block SHALL have port ram_dout, input, DATA_WIDTH, RAM read data.
REQ-013 The block SHALL have ports m_valid, m_data and m_last, outputs of width 1, DATA_WIDTH and 1, forming the stream output; m_ready, input, 1, is the stream backpressure.

Function
REQ-014 The RAM port SHALL be treated as a 2-stage read pipeline in which both the address register and the data register advance only on edges with ram_en=1.
REQ-015 Pipeline advance SHALL be defined as adv = !v2 || m_ready, and ram_en SHALL equal adv in every state.
REQ-016 Valid flags SHALL follow: on each edge with adv=1, v1 <= issuing and v2 <= v1; when adv=0, v1 and v2 SHALL hold.
REQ-017 Outputs SHALL follow: m_valid=v2, m_data=ram_dout, and m_last=v2 && (beat is the length-th word).
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-019 In IDLE with start=1 and length>0, the FSM SHALL go to RUN and load addr=base_addr and remaining=length.
REQ-020 In IDLE with start=1 and length=0, the FSM SHALL stay in IDLE, pulse done on the next cycle, emit no beat, and leave busy low.
REQ-021 In RUN, issuing SHALL be 1, and ram_addr=addr; each advancing edge SHALL increment addr (MEM_SIZE-1 wraps to 0, with an explicit compare so non-power-of-two sizes work) and decrement remaining; when the final address issues, the FSM SHALL go to DRAIN.
REQ-022 In DRAIN, issuing SHALL be 0 and ram_addr SHALL hold its last value; when the m_last beat is accepted (m_valid && m_ready && m_last), the FSM SHALL go to IDLE and assert done for one cycle.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 start while busy SHALL be ignored with no effect.
REQ-025 Latency SHALL be: start accepted at edge E0, first ram_addr presented in the cycle after E0, first m_valid 2 advancing edges later (3 cycles after the start cycle with no backpressure).
REQ-026 Throughput SHALL be 1 word per cycle while m_ready=1.
REQ-027 While m_ready=0 with m_valid=1, m_data, m_last, ram_addr and all counters SHALL be stable.
REQ-028 length=MEM_SIZE SHALL read every word exactly once, starting at base_addr, with wrap.

Reset
REQ-029 On rst_n=0, the block SHALL asynchronously return to IDLE with v1=v2=0, addr=0, remaining=0, busy=0, done=0, m_valid=0, m_last=0, ram_en=1 (adv), ram_we=0 and ram_addr=0.
REQ-030 A reset mid-burst SHALL abandon the burst without a done pulse; the first start after reset release SHALL behave identically to one issued after power-up.
REQ-031 Reset deassertion SHALL be synchronised externally; no internal synchroniser SHALL be present.

Structure
REQ-032 A shared package ram_reader_pkg SHALL hold the state enum (IDLE/RUN/DRAIN) and default ADDR_WIDTH/DATA_WIDTH/MEM_SIZE constants.
REQ-033 The block SHALL contain no sub-module; FSM, address counter and valid pipeline stay in ram_stream_reader.
REQ-034 The bench SHALL instantiate dual_port_ram, with port A preloaded via its write interface and port B driven by this block.

Verification
REQ-035 Preload ram[i]=i+100; start, base=5, length=4, m_ready=1 -> data 105,106,107,108 on 4 consecutive cycles, first beat 3 cycles after start, m_last on 108, done 1 cycle after.
REQ-036 Base=126, length=4 -> data 226,227,100,101 (wrap at 127->0).
REQ-037 Base=0, length=8, m_ready toggling 1,0,0,1,... -> 100..107 exactly once, in order, m_data held during stalls, no loss or duplicates.
REQ-038 Length=0 -> no m_valid, done pulse next cycle, busy never high.
REQ-039 Length=128, base=64 -> 128 beats, data 164..227 then 100..163; start pulsed mid-burst -> ignored.
REQ-040 Reset asserted in the 3rd beat of a length-10 burst -> outputs take their reset values immediately; new start base=0, length=2 -> 100,101, done.
